// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin / fixed-select stream mux.
// Mode encodings and a ceiling-log2 helper used to derive index widths.
package mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: highest priority is the channel just after ptr.
// Emits a one-hot grant, its index, and whether any request was granted.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = 8,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    logic [SELW-1:0] idx;

    // Walk the rotated order ptr+1 .. ptr; the first requester found wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int j = 0; j < N; j++) begin
            idx = SELW'((int'(ptr) + 1 + j) % N);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux onto one registered output stream.
// Round-robin arbitration (mode=0) or fixed channel select (mode=1).
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int N     = 8,
    localparam int SELW  = clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic [SELW-1:0]  ptr_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SELW-1:0]  out_sel_reg;

    logic [N-1:0]     rr_gnt;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic [N-1:0]     fixed_gnt;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic             grant_any;
    logic             load;
    logic [WIDTH-1:0] masked [N];
    logic [WIDTH-1:0] data_next;

    rr_arbiter #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_reg),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    // An out-of-range sel matches no channel, so it yields no grant.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign fixed_gnt[gi] = (sel == SELW'(gi)) & in_valid[gi];
            assign masked[gi]    = in_data[gi*WIDTH +: WIDTH] & {WIDTH{grant[gi]}};
        end
    endgenerate

    always_comb begin
        grant     = rr_gnt;
        grant_idx = rr_idx;
        grant_any = rr_any;
        if (mode == MODE_FIXED) begin
            grant     = fixed_gnt;
            grant_idx = sel;
            grant_any = |fixed_gnt;
        end
    end

    always_comb begin
        data_next = '0;
        for (int i = 0; i < N; i++) begin
            data_next = data_next | masked[i];
        end
    end

    assign load     = ~out_valid_reg | out_ready;
    // Gate with rst_n so no channel sees ready while reset is asserted.
    assign in_ready = grant & {N{load & rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            ptr_reg       <= SELW'(N - 1);
        end else if (load) begin
            if (grant_any) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= data_next;
                out_sel_reg   <= grant_idx;
                ptr_reg       <= grant_idx;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule
